// File: rtl/lsu_exec.sv
// Execute/memory stage of the load/store unit: effective address, alignment check,
// one valid/ready data-memory request, and load data alignment/extension for writeback.
module lsu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_nop,
    input  logic            in_zero_ext,
    input  logic [1:0]      in_size,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [4:0]      in_rd,
    input  logic [11:0]     in_imm,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        WB
    } state_t;

    state_t state;
    state_t state_next;

    logic            accept;
    logic            issue;
    logic            misaligned;
    logic            misalign_hit;
    logic            size_byte;
    logic            size_half;
    logic            size_word;
    logic [XLEN-1:0] eff_addr;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;

    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            zext_q;
    logic [4:0]      rd_q;
    logic            is_load_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] wb_data_q;
    logic [4:0]      wb_rd_q;
    logic            misalign_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_result;

    assign accept    = (state == IDLE) && in_valid;
    assign eff_addr  = in_rs1_val + {{(XLEN-12){in_imm[11]}}, in_imm};
    assign size_byte = (in_size == 2'd0);
    assign size_half = (in_size == 2'd1);
    assign size_word = in_size[1];

    assign misaligned   = (size_half && eff_addr[0]) || (size_word && (eff_addr[1:0] != 2'b00));
    assign issue        = accept && !in_is_nop && !misaligned;
    assign misalign_hit = accept && !in_is_nop && misaligned;

    // Store data is replicated across lanes so the memory only needs the byte enables.
    always_comb begin
        st_wdata = in_rs2_val;
        st_wstrb = 4'b1111;
        if (size_byte) begin
            st_wdata = {4{in_rs2_val[7:0]}};
            st_wstrb = 4'b0001 << eff_addr[1:0];
        end else if (size_half) begin
            st_wdata = {2{in_rs2_val[15:0]}};
            st_wstrb = 4'b0011 << eff_addr[1:0];
        end
        if (in_is_load) begin
            st_wstrb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0: ld_result = zext_q ? {{(XLEN-8){1'b0}}, ld_byte}
                                     : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            2'd1: ld_result = zext_q ? {{(XLEN-16){1'b0}}, ld_half}
                                     : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Responses are only looked at in WAIT_RSP, so one arriving alongside the handshake is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = is_load_q ? WAIT_RSP : IDLE;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_next = WB;
                end
            end
            WB: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        case (state)
            IDLE:     in_ready = 1'b1;
            REQ:      mem_req_valid = 1'b1;
            WB:       wb_valid = (wb_rd_q != 5'd0);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            rd_q       <= '0;
            is_load_q  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_hit;
            if (issue) begin
                addr_q    <= eff_addr;
                size_q    <= in_size;
                zext_q    <= in_zero_ext;
                rd_q      <= in_rd;
                is_load_q <= in_is_load;
                wdata_q   <= in_is_load ? '0 : st_wdata;
                wstrb_q   <= st_wstrb;
            end
            if ((state == WAIT_RSP) && mem_rsp_valid) begin
                wb_data_q <= ld_result;
                wb_rd_q   <= rd_q;
            end
        end
    end

    assign mem_we       = is_load_q ? 1'b0 : (addr_q != '0 || wstrb_q != 4'b0000);
    assign mem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;

endmodule
